// File: rtl/fifo_pkt_arbiter.sv
// Packet-atomic two-source arbiter in front of a single FIFO write port.
// A grant is held from the first accepted word through the EOF transfer, then one IDLE cycle re-arbitrates.
module fifo_pkt_arbiter #(
    parameter int WIDTH = 36,
    parameter bit PRIO  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_src_rdy,
    output logic             in0_dst_rdy,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_src_rdy,
    output logic             in1_dst_rdy,
    output logic [WIDTH-1:0] fifo_data,
    output logic             fifo_write,
    input  logic             fifo_full,
    output logic [1:0]       active,
    output logic [15:0]      pkt_count0,
    output logic [15:0]      pkt_count1
);
    localparam int EOF_BIT = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_served;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        eof_xfer0;
    logic        eof_xfer1;

    // fifo_full reaches the state register only through these transfer terms
    assign eof_xfer0 = (state == SEND0) & in0_src_rdy & ~fifo_full & in0_data[EOF_BIT];
    assign eof_xfer1 = (state == SEND1) & in1_src_rdy & ~fifo_full & in1_data[EOF_BIT];

    assign pkt_count0 = cnt0;
    assign pkt_count1 = cnt1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            last_served <= 1'b1;
            cnt0        <= 16'd0;
            cnt1        <= 16'd0;
        end else begin
            state <= state_next;
            if (eof_xfer0) begin
                cnt0        <= cnt0 + 16'd1;
                last_served <= 1'b0;
            end
            if (eof_xfer1) begin
                cnt1        <= cnt1 + 16'd1;
                last_served <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in0_src_rdy && in1_src_rdy)
                    state_next = (PRIO || last_served) ? SEND0 : SEND1;
                else if (in0_src_rdy)
                    state_next = SEND0;
                else if (in1_src_rdy)
                    state_next = SEND1;
            end
            SEND0:   if (eof_xfer0) state_next = IDLE;
            SEND1:   if (eof_xfer1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in0_dst_rdy = 1'b0;
        in1_dst_rdy = 1'b0;
        fifo_write  = 1'b0;
        fifo_data   = in0_data;
        active      = 2'b00;
        case (state)
            SEND0: begin
                in0_dst_rdy = ~fifo_full;
                fifo_write  = in0_src_rdy & ~fifo_full;
                active      = 2'b01;
            end
            SEND1: begin
                in1_dst_rdy = ~fifo_full;
                fifo_write  = in1_src_rdy & ~fifo_full;
                fifo_data   = in1_data;
                active      = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// Bench for fifo_pkt_arbiter: round-robin and strict-priority instances, each checked against a
// packet-level reference every cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_pkt_arbiter;
    localparam int W = 36;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic [W-1:0] in_data [2][2];
    logic         in_rdy  [2][2];
    logic         full    [2];
    logic         dst     [2][2];
    logic [W-1:0] f_data  [2];
    logic         f_wr    [2];
    logic [1:0]   act     [2];
    logic [15:0]  c0      [2];
    logic [15:0]  c1      [2];

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    logic full_ctl = 1'b0;

    logic [36:0]  sq0 [$];
    logic [36:0]  sq1 [$];
    logic [W-1:0] wlog [$];
    int           glog [$];

    int          mst   [2];
    logic        mlast [2];
    logic [15:0] mc0   [2];
    logic [15:0] mc1   [2];
    logic [1:0]  prev_act [2];
    logic        acc0;
    logic        acc1;

    always #5 clk = ~clk;

    fifo_pkt_arbiter #(.WIDTH(W), .PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .clear(clear),
        .in0_data(in_data[0][0]), .in0_src_rdy(in_rdy[0][0]), .in0_dst_rdy(dst[0][0]),
        .in1_data(in_data[0][1]), .in1_src_rdy(in_rdy[0][1]), .in1_dst_rdy(dst[0][1]),
        .fifo_data(f_data[0]), .fifo_write(f_wr[0]), .fifo_full(full[0]),
        .active(act[0]), .pkt_count0(c0[0]), .pkt_count1(c1[0])
    );

    fifo_pkt_arbiter #(.WIDTH(W), .PRIO(1'b1)) dut_sp (
        .clk(clk), .rst(rst), .clear(clear),
        .in0_data(in_data[1][0]), .in0_src_rdy(in_rdy[1][0]), .in0_dst_rdy(dst[1][0]),
        .in1_data(in_data[1][1]), .in1_src_rdy(in_rdy[1][1]), .in1_dst_rdy(dst[1][1]),
        .fifo_data(f_data[1]), .fifo_write(f_wr[1]), .fifo_full(full[1]),
        .active(act[1]), .pkt_count0(c0[1]), .pkt_count1(c1[1])
    );

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    function automatic logic [W-1:0] mkw(input bit sof, input bit eof, input logic [31:0] pay);
        return {2'b00, eof, sof, pay};
    endfunction

    task automatic push_pkt(input int s, input int n, input logic [31:0] base);
        logic [36:0] e;
        for (int i = 0; i < n; i++) begin
            e = {1'b1, mkw(i == 0, i == n - 1, base + i)};
            if (s == 0) sq0.push_back(e);
            else        sq1.push_back(e);
        end
    endtask

    task automatic apply_inputs();
        logic [36:0] h;
        for (int k = 0; k < 2; k++) begin
            in_rdy[k][0]  = 1'b0;
            in_rdy[k][1]  = 1'b0;
            in_data[k][0] = '0;
            in_data[k][1] = '0;
            full[k]       = 1'b0;
        end
        if (sq0.size() > 0) begin
            h = sq0[0];
            in_rdy[sel][0]  = h[36];
            in_data[sel][0] = h[W-1:0];
        end
        if (sq1.size() > 0) begin
            h = sq1[0];
            in_rdy[sel][1]  = h[36];
            in_data[sel][1] = h[W-1:0];
        end
        full[sel] = full_ctl;
    endtask

    // A source pops a bubble every cycle, a real word only when the reference says it was accepted
    task automatic finish_step();
        logic [36:0] h;
        logic a0, a1;
        @(posedge clk);
        a0 = acc0;
        a1 = acc1;
        #1;
        if (sq0.size() > 0) begin
            h = sq0[0];
            if (!h[36] || a0) void'(sq0.pop_front());
        end
        if (sq1.size() > 0) begin
            h = sq1[0];
            if (!h[36] || a1) void'(sq1.pop_front());
        end
    endtask

    task automatic step();
        apply_inputs();
        finish_step();
    endtask

    task automatic run(input int maxc, output int n);
        n = 0;
        while ((sq0.size() > 0 || sq1.size() > 0 || mst[sel] != 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            total++;
            bad++;
            $display("FAIL timeout actual=%0d cycles required=<%0d", n, maxc);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Reference: grant held per packet, one idle arbitration cycle after each EOF transfer
    always @(negedge clk) begin : compare
        int   g;
        logic ew;
        for (int k = 0; k < 2; k++) begin
            g  = mst[k] - 1;
            ew = 1'b0;
            if (g >= 0) ew = in_rdy[k][g] && !full[k];
            check($sformatf("active%0d", k), act[k], (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
            check($sformatf("dst0_%0d", k), dst[k][0], (g == 0) && !full[k]);
            check($sformatf("dst1_%0d", k), dst[k][1], (g == 1) && !full[k]);
            check($sformatf("write%0d", k), f_wr[k], ew);
            if (ew) check($sformatf("data%0d", k), f_data[k], in_data[k][g]);
            check($sformatf("cnt0_%0d", k), c0[k], mc0[k]);
            check($sformatf("cnt1_%0d", k), c1[k], mc1[k]);
            if (k == sel) begin
                if (f_wr[k] === 1'b1) wlog.push_back(f_data[k]);
                if (act[k] != 2'b00 && prev_act[k] == 2'b00) glog.push_back(act[k] == 2'b01 ? 0 : 1);
                acc0 = ew && (g == 0);
                acc1 = ew && (g == 1);
            end
            prev_act[k] = act[k];
            if (rst || clear) begin
                mst[k] = 0; mlast[k] = 1'b1; mc0[k] = 16'd0; mc1[k] = 16'd0;
            end else if (g < 0) begin
                if (in_rdy[k][0] && in_rdy[k][1]) mst[k] = (k == 1 || mlast[k]) ? 1 : 2;
                else if (in_rdy[k][0])            mst[k] = 1;
                else if (in_rdy[k][1])            mst[k] = 2;
            end else if (ew && in_data[k][g][33]) begin
                if (g == 0) mc0[k] = mc0[k] + 16'd1;
                else        mc1[k] = mc1[k] + 16'd1;
                mlast[k] = (g == 1);
                mst[k]   = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [36:0]  h;
        logic [W-1:0] w3;
        rst = 1'b1;
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mlast[k] = 1'b1; mc0[k] = 16'd0; mc1[k] = 16'd0; prev_act[k] = 2'b00;
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_active_rr", act[0], 2'b00);
        check("rst_active_sp", act[1], 2'b00);
        check("rst_cnt0", c0[0], 16'd0);
        check("rst_cnt1", c1[0], 16'd0);

        // Single 4-word packet from source 0
        wlog.delete(); glog.delete();
        push_pkt(0, 4, 32'h100);
        step();
        check("s1_grant", act[0], 2'b01);
        run(20, n);
        check("s1_cycles", n + 1, 5);
        check("s1_idle", act[0], 2'b00);
        check("s1_count0", c0[0], 16'd1);
        check("s1_nwords", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            check("s1_word", wlog[i], mkw(i == 0, i == 3, 32'h100 + i));

        // Round-robin with both sources continuously offering 3-word packets
        do_clear();
        wlog.delete(); glog.delete();
        push_pkt(0, 3, 32'h000); push_pkt(0, 3, 32'h010);
        push_pkt(1, 3, 32'h100); push_pkt(1, 3, 32'h110);
        run(40, n);
        check("rr_cycles", n, 16);
        check("rr_ngrants", glog.size(), 4);
        for (int j = 0; j < 4 && j < glog.size(); j++) check("rr_order", glog[j], j % 2);
        check("rr_nwords", wlog.size(), 12);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 3; i++)
                if (3 * j + i < wlog.size())
                    check("rr_word", wlog[3 * j + i],
                          mkw(i == 0, i == 2, ((j % 2) << 8) + ((j / 2) << 4) + i));
        check("rr_cnt0", c0[0], 16'd2);
        check("rr_cnt1", c1[0], 16'd2);

        // Strict priority instance: source 1 waits until source 0 runs dry
        sel = 1;
        do_clear();
        wlog.delete(); glog.delete();
        push_pkt(0, 2, 32'h200); push_pkt(0, 2, 32'h210); push_pkt(0, 2, 32'h220);
        push_pkt(1, 2, 32'h300);
        n = 0;
        while (sq0.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check("sp_cnt1_hold", c1[1], 16'd0);
        check("sp_cnt0", c0[1], 16'd3);
        run(20, n);
        check("sp_ngrants", glog.size(), 4);
        for (int j = 0; j < 4 && j < glog.size(); j++) check("sp_order", glog[j], (j == 3) ? 1 : 0);
        check("sp_cnt1", c1[1], 16'd1);

        // Backpressure: three full cycles in the middle of a 5-word packet
        sel = 0;
        wlog.delete(); glog.delete();
        push_pkt(0, 5, 32'h400);
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            full_ctl = 1'b1;
            apply_inputs();
            #2;
            check("bp_write", f_wr[0], 1'b0);
            check("bp_dst", dst[0][0], 1'b0);
            finish_step();
        end
        full_ctl = 1'b0;
        run(20, n);
        check("bp_nwords", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check("bp_word", wlog[i], mkw(i == 0, i == 4, 32'h400 + i));
        check("bp_cnt0", c0[0], 16'd1);

        // Source 1 stalls mid-packet, then clear lands on its EOF transfer
        wlog.delete(); glog.delete();
        push_pkt(0, 1, 32'h500);
        w3 = mkw(1'b0, 1'b1, 32'h603);
        sq1.push_back({1'b1, mkw(1'b1, 1'b0, 32'h600)});
        sq1.push_back({1'b1, mkw(1'b0, 1'b0, 32'h601)});
        sq1.push_back({1'b0, {W{1'b0}}});
        sq1.push_back({1'b0, {W{1'b0}}});
        sq1.push_back({1'b1, mkw(1'b0, 1'b0, 32'h602)});
        sq1.push_back({1'b1, w3});
        push_pkt(1, 1, 32'h610);
        step();
        check("stall_grant1", act[0], 2'b10);
        n = 0;
        h = sq1[0];
        while (h != {1'b1, w3} && n < 10) begin
            check("stall_hold", act[0], 2'b10);
            step();
            n++;
            h = sq1[0];
        end
        check("stall_steps", n, 5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_active", act[0], 2'b00);
        check("clear_cnt0", c0[0], 16'd0);
        check("clear_cnt1", c1[0], 16'd0);
        glog.delete();
        run(20, n);
        check("clear_ngrants", glog.size(), 2);
        if (glog.size() > 1) begin
            check("clear_tie", glog[0], 0);
            check("clear_next", glog[1], 1);
        end
        check("clear_after_cnt0", c0[0], 16'd1);
        check("clear_after_cnt1", c1[0], 16'd1);

        // Counter wrap: preload near the top, then three one-word EOF packets
        do_clear();
        force dut_rr.cnt0 = 16'hFFFD;
        mc0[0] = 16'hFFFD;
        #1;
        release dut_rr.cnt0;
        #1;
        check("wrap_preset", c0[0], 16'hFFFD);
        push_pkt(0, 1, 32'h700); push_pkt(0, 1, 32'h701); push_pkt(0, 1, 32'h702);
        run(20, n);
        check("wrap_cycles", n, 6);
        check("wrap_cnt0", c0[0], 16'h0000);
        check("wrap_active", act[0], 2'b00);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_pkt_arbiter.md
# fifo_pkt_arbiter

Two-input, packet-atomic arbiter that shares the write port of a single block-RAM FIFO between two 36-bit packet sources. It selects one source at a time and forwards that source's whole packet, start-of-frame through end-of-frame, before it re-arbitrates. It sits directly in front of the FIFO's write side and converts each source's src_rdy/dst_rdy handshake into the FIFO's write strobe, with backpressure taken from the FIFO's full flag. Per-input packet counters are provided for diagnostics.

## Interface
- WIDTH, 36: data width; bit 32 = SOF, bit 33 = EOF.
- PRIO, 0: 0 = round-robin between inputs; 1 = strict priority to input 0.
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous soft reset; same effect as rst
- in0_data  input  WIDTH  source 0 data
- in0_src_rdy  input  1  source 0 has a valid word
- in0_dst_rdy  output  1  source 0 word accepted this cycle
- in1_data  input  WIDTH  source 1 data
- in1_src_rdy  input  1  source 1 has a valid word
- in1_dst_rdy  output  1  source 1 word accepted this cycle
- fifo_data  output  WIDTH  data to FIFO write port
- fifo_write  output  1  FIFO write strobe
- fifo_full  input  1  FIFO full flag
- active  output  2  one-hot current grant; 00 when idle
- pkt_count0  output  16  packets forwarded from source 0
- pkt_count1  output  16  packets forwarded from source 1

## Operation
- States: IDLE, SEND0, SEND1. Reset/clear value: IDLE, active=00, pkt_count0/1=0, last-served register=1, so source 0 wins the first tie.
- IDLE:
  - in0_src_rdy only -> SEND0.
  - in1_src_rdy only -> SEND1.
  - Both ready, PRIO=0 -> grant the source not last served.
  - Both ready, PRIO=1 -> SEND0.
  - No transfer occurs in IDLE: fifo_write=0, both dst_rdy=0.
- SENDx:
  - inx_dst_rdy = ~fifo_full.
  - The other source's dst_rdy = 0.
  - fifo_data = inx_data, combinational mux.
  - fifo_write = inx_src_rdy & ~fifo_full.
- Transfer: a transfer is a cycle with fifo_write=1. A transfer with EOF (bit 33) set increments pkt_countx, sets last-served=x, and moves the state to IDLE.
- Packet integrity:
  - The grant never changes before an EOF transfer.
  - SOF is not checked. The arbiter forwards words as given.
  - A source deasserting src_rdy mid-packet holds the grant; other sources wait.
- Counters are 16 bits and wrap from 0xFFFF to 0x0000 without saturating.
- active = 01 in SEND0, 10 in SEND1, 00 in IDLE. It is a registered state decode.
- clear mid-packet: the state returns to IDLE on the next edge and the partial packet is truncated in the FIFO. Recovery belongs to downstream logic. The next grant follows normal IDLE rules.

## Timing
- Grant latency: one cycle from src_rdy seen in IDLE to the first possible transfer.
- Throughput inside a packet: one word per cycle while src_rdy=1 and fifo_full=0.
- Packet boundary: exactly one IDLE cycle after each EOF transfer. An N-word packet occupies N+1 cycles minimum.
- fifo_full is sampled combinationally in the same cycle. No write is issued in any cycle where fifo_full=1.
- Simultaneous EOF transfer and clear: clear wins and the counter does not increment.
- Simultaneous rst and any event: rst wins.
- All state, last-served and counters update on posedge clk only.
- No combinational path from fifo_full to the state register other than through the transfer condition.

## Test plan
- Single source: source 0 sends a 4-word packet, SOF on word 0 and EOF on word 3, with fifo_full=0.
  - Required: active=01 one cycle after src_rdy, 4 consecutive fifo_write pulses, data in order.
  - Then IDLE for 1 cycle, pkt_count0=1.
- Round-robin (PRIO=0): both sources continuously offer 3-word packets.
  - Required grant order: 0,1,0,1.
  - Each packet is contiguous with no interleaved words.
  - After 4 packets: pkt_count0=2, pkt_count1=2.
- Strict priority (PRIO=1): both sources continuously offer packets.
  - Required: only source 0 is granted; pkt_count1 stays 0.
  - Then drop in0_src_rdy: source 1 is granted at the next IDLE.
- Backpressure: assert fifo_full for 3 cycles in the middle of a 5-word packet.
  - Required: fifo_write=0 and inx_dst_rdy=0 during those cycles, no word lost or duplicated, 5 writes total.
- Mid-packet stall and clear:
  - Source 1 stalls src_rdy for 2 cycles mid-packet. Required: grant held, source 0 not granted.
  - Then pulse clear. Required: active=00 next cycle, counters=0, the next grant goes to source 0 on a tie.
- Counter wrap: force 65536 one-word EOF packets from source 0.
  - Required: pkt_count0 reads 0x0000 afterwards, with no stall or state error.
